// File: rtl/pad_ctrl_pkg.sv
// Shared types for the pad bank controller: per-pad config record, its reset value,
// commit sequencer states and the pull-resolution helper.
package pad_ctrl_pkg;

    typedef struct packed {
        logic oe;
        logic cs;
        logic sl;
        logic ie;
        logic pu;
        logic pd;
    } pad_cfg_t;

    localparam pad_cfg_t PAD_CFG_RESET = '{oe: 1'b0, cs: 1'b0, sl: 1'b0, ie: 1'b1, pu: 1'b0, pd: 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DROP   = 3'd1,
        ST_SET1   = 3'd2,
        ST_APPLY  = 3'd3,
        ST_SET2   = 3'd4,
        ST_ENABLE = 3'd5
    } commit_state_e;

    // Pull-up and pull-down together would fight; pull-up wins.
    function automatic pad_cfg_t resolve_pulls(input pad_cfg_t cfg);
        pad_cfg_t res;
        res = cfg;
        if (cfg.pu && cfg.pd) begin
            res.pd = 1'b0;
        end else begin
            res.pd = cfg.pd;
        end
        return res;
    endfunction

endpackage

// File: rtl/pad_in_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset.
module pad_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // shift chain; output is the last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pad_bank_ctrl.sv
// Bank of bidirectional pad controls with shadow/active config and a glitch-safe commit sequence.
// Optional active-config readback port is built when PADCTRL_READBACK_EN is defined.
module pad_bank_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int NUM_CH        = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2,
    localparam int CHW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr_valid,
    output logic              cfg_wr_ready,
    input  logic [CHW-1:0]    cfg_wr_ch,
    input  logic [5:0]        cfg_wr_data,
    input  logic              cfg_commit,
    output logic              commit_busy,
    input  logic [NUM_CH-1:0] core_out,
    output logic [NUM_CH-1:0] core_in,
    input  logic [NUM_CH-1:0] pad_in,
    output logic [NUM_CH-1:0] pad_out,
    output logic [NUM_CH-1:0] pad_oe,
    output logic [NUM_CH-1:0] pad_cs,
    output logic [NUM_CH-1:0] pad_sl,
    output logic [NUM_CH-1:0] pad_ie,
    output logic [NUM_CH-1:0] pad_pu,
    output logic [NUM_CH-1:0] pad_pd
`ifdef PADCTRL_READBACK_EN
    ,
    input  logic [CHW-1:0]    cfg_rd_ch,
    output logic [5:0]        cfg_rd_data
`endif
);

    localparam int CNTW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNTW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CNTW'(SETTLE_CYCLES - 1) : '0;
    localparam logic [CHW:0]    NUM_CH_W    = NUM_CH[CHW:0];

    pad_cfg_t      shadow_q [NUM_CH];
    pad_cfg_t      active_q [NUM_CH];
    commit_state_e state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic          wr_en_s;

    assign commit_busy  = (state_q != ST_IDLE);
    assign cfg_wr_ready = ~commit_busy;
    assign wr_en_s      = cfg_wr_valid && cfg_wr_ready && ({1'b0, cfg_wr_ch} < NUM_CH_W);

    // shadow register file; writes only land while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= PAD_CFG_RESET;
            end
        end else if (wr_en_s) begin
            shadow_q[cfg_wr_ch] <= resolve_pulls(pad_cfg_t'(cfg_wr_data));
        end
    end

    // commit sequencer state and settle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next-state: settle states are skipped entirely when no wait is configured
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_commit) state_d = ST_DROP;
                else            state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (SETTLE_CYCLES == 0) begin
                    state_d = ST_APPLY;
                end else begin
                    state_d = ST_SET1;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ST_SET1: begin
                if (cnt_q == '0) state_d = ST_APPLY;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_APPLY: begin
                if (SETTLE_CYCLES == 0) begin
                    state_d = ST_ENABLE;
                end else begin
                    state_d = ST_SET2;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ST_SET2: begin
                if (cnt_q == '0) state_d = ST_ENABLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_ENABLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // active config: each phase updates at the end of its own cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                active_q[i] <= PAD_CFG_RESET;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                case (state_q)
                    ST_DROP:   active_q[i].oe <= active_q[i].oe & shadow_q[i].oe;
                    ST_APPLY: begin
                        active_q[i].cs <= shadow_q[i].cs;
                        active_q[i].sl <= shadow_q[i].sl;
                        active_q[i].ie <= shadow_q[i].ie;
                        active_q[i].pu <= shadow_q[i].pu;
                        active_q[i].pd <= shadow_q[i].pd;
                    end
                    ST_ENABLE: active_q[i].oe <= shadow_q[i].oe;
                    default:   active_q[i]    <= active_q[i];
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign pad_oe[g] = active_q[g].oe;
        assign pad_cs[g] = active_q[g].cs;
        assign pad_sl[g] = active_q[g].sl;
        assign pad_ie[g] = active_q[g].ie;
        assign pad_pu[g] = active_q[g].pu;
        assign pad_pd[g] = active_q[g].pd;

        pad_in_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d_i (pad_in[g] & active_q[g].ie),
            .q_o (core_in[g])
        );
    end

    assign pad_out = core_out & pad_oe;

`ifdef PADCTRL_READBACK_EN
    // registered readback of the active config; out-of-range channels read zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_rd_data <= PAD_CFG_RESET;
        end else if ({1'b0, cfg_rd_ch} < NUM_CH_W) begin
            cfg_rd_data <= active_q[cfg_rd_ch];
        end else begin
            cfg_rd_data <= 6'b000000;
        end
    end
`endif

endmodule

// File: tb/tb_pad_bank_ctrl.sv
// Directed bench for pad_bank_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pad_bank_ctrl;

    localparam int SEL_BUSY  = 0;
    localparam int SEL_OE    = 1;
    localparam int SEL_IE    = 2;
    localparam int SEL_PU    = 3;
    localparam int SEL_PD    = 4;
    localparam int SEL_OUT   = 5;
    localparam int SEL_CIN   = 6;
    localparam int SEL_READY = 7;
    localparam int SEL_CS    = 8;
    localparam int SEL_SL    = 9;

    typedef struct {
        int          cyc;
        int          sel;
        logic [7:0]  val;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_wr_valid = 1'b0;
    logic       cfg_wr_ready;
    logic [2:0] cfg_wr_ch = 3'd0;
    logic [5:0] cfg_wr_data = 6'd0;
    logic       cfg_commit = 1'b0;
    logic       commit_busy;
    logic [7:0] core_out = 8'h00;
    logic [7:0] core_in;
    logic [7:0] pad_in = 8'h00;
    logic [7:0] pad_out, pad_oe, pad_cs, pad_sl, pad_ie, pad_pu, pad_pd;

    exp_t sb_q[$];
    int   cyc_cnt = 0;
    int   total = 0;
    int   bad = 0;

    pad_bank_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_wr_valid (cfg_wr_valid),
        .cfg_wr_ready (cfg_wr_ready),
        .cfg_wr_ch    (cfg_wr_ch),
        .cfg_wr_data  (cfg_wr_data),
        .cfg_commit   (cfg_commit),
        .commit_busy  (commit_busy),
        .core_out     (core_out),
        .core_in      (core_in),
        .pad_in       (pad_in),
        .pad_out      (pad_out),
        .pad_oe       (pad_oe),
        .pad_cs       (pad_cs),
        .pad_sl       (pad_sl),
        .pad_ie       (pad_ie),
        .pad_pu       (pad_pu),
        .pad_pd       (pad_pd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [7:0] get_sig(input int sel);
        case (sel)
            SEL_BUSY:  return {7'd0, commit_busy};
            SEL_OE:    return pad_oe;
            SEL_IE:    return pad_ie;
            SEL_PU:    return pad_pu;
            SEL_PD:    return pad_pd;
            SEL_OUT:   return pad_out;
            SEL_CIN:   return core_in;
            SEL_READY: return {7'd0, cfg_wr_ready};
            SEL_CS:    return pad_cs;
            SEL_SL:    return pad_sl;
            default:   return 8'hxx;
        endcase
    endfunction

    // monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= cyc_cnt) begin
                logic [7:0] act;
                act = get_sig(sb_q[i].sel);
                total++;
                if (act !== sb_q[i].val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", sb_q[i].name, cyc_cnt, act, sb_q[i].val);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic expect_at(input int off, input int sel, input logic [7:0] val, input string nm);
        exp_t e;
        e.cyc  = cyc_cnt + off;
        e.sel  = sel;
        e.val  = val;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_commit(input logic [2:0] ch, input logic [5:0] d, input logic wr, input logic cm);
        cfg_wr_valid = wr;
        cfg_wr_ch    = ch;
        cfg_wr_data  = d;
        cfg_commit   = cm;
        step(1);
        cfg_wr_valid = 1'b0;
        cfg_commit   = 1'b0;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(1);

        // 1: reset state
        core_out = 8'hFF;
        expect_at(0, SEL_OE,    8'h00, "rst_oe");
        expect_at(0, SEL_IE,    8'hFF, "rst_ie");
        expect_at(0, SEL_PD,    8'hFF, "rst_pd");
        expect_at(0, SEL_PU,    8'h00, "rst_pu");
        expect_at(0, SEL_OUT,   8'h00, "rst_out");
        expect_at(0, SEL_CIN,   8'h00, "rst_cin");
        expect_at(0, SEL_BUSY,  8'h00, "rst_busy");
        expect_at(0, SEL_READY, 8'h01, "rst_ready");
        #1;
        total++;
        if (pad_oe !== 8'h00) begin
            bad++;
            $display("FAIL rst_oe_direct got=%h want=%h", pad_oe, 8'h00);
        end
        total++;
        if (pad_out !== 8'h00) begin
            bad++;
            $display("FAIL rst_out_direct got=%h want=%h", pad_out, 8'h00);
        end
        total++;
        if (core_in !== 8'h00) begin
            bad++;
            $display("FAIL rst_cin_direct got=%h want=%h", core_in, 8'h00);
        end
        total++;
        if (commit_busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy_direct got=%b want=0", commit_busy);
        end
        step(1);

        // 2: enable ch3 output, write and commit in the same cycle
        expect_at(0,  SEL_BUSY,  8'h00, "t2_busy_pre");
        expect_at(1,  SEL_BUSY,  8'h01, "t2_busy_first");
        expect_at(1,  SEL_READY, 8'h00, "t2_ready_busy");
        expect_at(11, SEL_BUSY,  8'h01, "t2_busy_last");
        expect_at(11, SEL_OE,    8'h00, "t2_oe_enable_cycle");
        expect_at(12, SEL_BUSY,  8'h00, "t2_busy_end");
        expect_at(12, SEL_OE,    8'h08, "t2_oe_up");
        expect_at(12, SEL_OUT,   8'h08, "t2_out");
        write_commit(3'd3, 6'b100101, 1'b1, 1'b1);
        step(13);

        // 3: disable ch3 output and input
        expect_at(1, SEL_OE, 8'h08, "t3_oe_drop_cycle");
        expect_at(2, SEL_OE, 8'h00, "t3_oe_down");
        expect_at(6, SEL_IE, 8'hFF, "t3_ie_before");
        expect_at(7, SEL_IE, 8'hF7, "t3_ie_after");
        expect_at(7, SEL_PD, 8'hF7, "t3_pd_after");
        expect_at(7, SEL_OUT, 8'h00, "t3_out_off");
        write_commit(3'd3, 6'b000000, 1'b1, 1'b1);
        step(13);

        // 4: pull conflict on ch0, and a write attempted while busy
        expect_at(12, SEL_PU, 8'h01, "t4_pu");
        expect_at(12, SEL_PD, 8'hF6, "t4_pd");
        expect_at(12, SEL_IE, 8'hF6, "t4_ie");
        write_commit(3'd0, 6'b000011, 1'b1, 1'b1);
        step(2);
        expect_at(0, SEL_READY, 8'h00, "t4_ready_busy");
        write_commit(3'd0, 6'b011000, 1'b1, 1'b0);
        step(12);
        expect_at(12, SEL_CS, 8'h00, "t4_cs_unchanged");
        expect_at(12, SEL_SL, 8'h00, "t4_sl_unchanged");
        expect_at(12, SEL_PU, 8'h01, "t4_pu_kept");
        expect_at(12, SEL_PD, 8'hF6, "t4_pd_kept");
        write_commit(3'd0, 6'b000000, 1'b0, 1'b1);
        step(13);

        // 6: input synchroniser on ch5 (ie=1) and ch3 (ie=0)
        pad_in = 8'h20;
        expect_at(1, SEL_CIN, 8'h00, "t6_cin_lat1");
        expect_at(2, SEL_CIN, 8'h20, "t6_cin_rise");
        step(3);
        pad_in = 8'h00;
        expect_at(1, SEL_CIN, 8'h20, "t6_cin_hold");
        expect_at(2, SEL_CIN, 8'h00, "t6_cin_fall");
        step(3);
        pad_in = 8'h08;
        expect_at(2, SEL_CIN, 8'h00, "t6_cin_gated");
        expect_at(4, SEL_CIN, 8'h00, "t6_cin_gated2");
        step(5);
        pad_in = 8'h00;

        // 5: reset asserted while in the second settle phase
        expect_at(7, SEL_BUSY, 8'h01, "t5_busy_set2");
        write_commit(3'd1, 6'b100101, 1'b1, 1'b1);
        step(7);
        rst = 1'b1;
        expect_at(0, SEL_BUSY,  8'h00, "t5_busy_rst");
        expect_at(0, SEL_READY, 8'h01, "t5_ready_rst");
        expect_at(0, SEL_OE,    8'h00, "t5_oe_rst");
        expect_at(0, SEL_IE,    8'hFF, "t5_ie_rst");
        expect_at(0, SEL_PD,    8'hFF, "t5_pd_rst");
        expect_at(0, SEL_PU,    8'h00, "t5_pu_rst");
        expect_at(0, SEL_CIN,   8'h00, "t5_cin_rst");
        #1;
        total++;
        if (commit_busy !== 1'b0) begin
            bad++;
            $display("FAIL t5_busy_direct got=%b want=0", commit_busy);
        end
        total++;
        if (pad_oe !== 8'h00) begin
            bad++;
            $display("FAIL t5_oe_direct got=%h want=%h", pad_oe, 8'h00);
        end
        total++;
        if (cfg_wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL t5_ready_direct got=%b want=1", cfg_wr_ready);
        end
        step(2);
        rst = 1'b0;

        for (int k = 0; k < 50 && sb_q.size() != 0; k++) begin
            step(1);
        end
        foreach (sb_q[i]) begin
            total++;
            bad++;
            $display("FAIL %s never_checked got=none want=%h", sb_q[i].name, sb_q[i].val);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
